display_scheduler: RTL and testbench
====================================

# display_scheduler

Time-shares the board's 4-digit common-anode 7-segment display between two requesters, such as the input/keypad path and the result path. It arbitrates with a req/gnt level handshake and enforces a round-robin time slice under contention. It also drives the multiplexed anode scan and segment outputs for the granted requester's 16-bit value. It sits between the datapath producers and the top-level `seg`/`an` pins, running on the 10 MHz wizard clock.

## Interface

- `SCAN_DIV`, default 10000: clk_i cycles per digit (1 kHz digit rate at 10 MHz); must be ≥ 2.
- `HOLD_CYC`, default 5000000: time slice in cycles (0.5 s) before a contended owner is preempted; must be ≥ 2.
- `clk_i`, in, 1: single clock, the 10 MHz wizard output.
- `rst_i`, in, 1: reset, synchronous and active-high.
- `req_i`, in, 2: level request per requester; held high while the display is wanted.
- `data0_i`, in, 16: four hex nibbles from requester 0; [3:0] goes to the rightmost digit.
- `data1_i`, in, 16: four hex nibbles from requester 1.
- `gnt_o`, out, 2: one-hot grant, or 00 when idle; registered.
- `an_o`, out, 4: anodes, active-low, one low at a time; 1111 when blank.
- `seg_o`, out, 7: segments abcdefg, active-low; 1111111 when blank.

## Operation

- The FSM has three states: IDLE, OWN0 and OWN1. `gnt_o` is a decode of the state.
- `last_q` holds the last-served requester. It resets to 1, so requester 0 wins the first tie.
- IDLE transitions:
  - If both requests are high, go to the OWN state of the requester that is not `last_q`.
  - If one request is high, go to that requester's OWN state.
  - If neither is high, stay in IDLE.
- OWNx transitions, evaluated in this order:
  - `req_i[x]` low and the other request high: go to OWN of the other requester.
  - `req_i[x]` low and the other request low: go to IDLE.
  - `req_i[x]` high, the other request high, and `slice_q == HOLD_CYC-1`: go to OWN of the other requester (preemption).
  - Otherwise stay in OWNx.
- `last_q` updates on every entry to an OWN state.
- `slice_q` behaviour:
  - Clears on every state change.
  - Increments in OWN only while the other request is high, saturating at HOLD_CYC-1.
  - Clears while the other request is low, so an uncontested owner keeps the display indefinitely.
- Scan behaviour:
  - The prescaler `div_q` counts 0..SCAN_DIV-1 and wraps.
  - At the terminal count, the digit index `idx_q` advances 0→1→2→3→0.
  - Both counters run in every state, including IDLE.
- Output mapping by `idx_q`:
  - idx 0: nibble [3:0], an 1110.
  - idx 1: nibble [7:4], an 1101.
  - idx 2: nibble [11:8], an 1011.
  - idx 3: nibble [15:12], an 0111.
- Source selection: the nibble comes from the data input of the granted requester, sampled live every cycle with no latching.
- When blank (IDLE), the outputs are an 1111 and seg 1111111.
- Hex encoding is active-low abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000.

## Timing

- Reset values: state IDLE, `gnt_o` 00, `an_o` 1111, `seg_o` 1111111, `last_q` 1, `div_q` 0, `idx_q` 0, `slice_q` 0.
- Grant latency: a request sampled at edge n produces `gnt_o` at edge n+1 when the display is free.
- Release latency: `req_i[x]` falling at edge n produces `gnt_o[x]` 0 at edge n+1.
- Grant handoff has no dead cycle: release and the other grant occur at the same edge.
- `an_o` and `seg_o` are registered from the state, `idx_q` and data, so they lag those signals by one cycle. The display turns on one cycle after `gnt_o` rises.
- Grant changes are not aligned to digit boundaries; the scan is not restarted on a handoff.
- Release and slice expiry in the same cycle: the release branch wins, giving the same result (handoff to the other requester).
- Reset asserted mid-operation: on the next edge, everything returns to its reset values regardless of `req_i`.
- Width rules: counter widths are `$clog2` of their terminal count (+1 where needed). No counter overflows past its terminal count.

## Structure

- Package `disp_pkg` contains:
  - the `disp_state_t` enum (IDLE, OWN0, OWN1);
  - the constants `AN_OFF` = 4'b1111 and `SEG_BLANK` = 7'b1111111;
  - a function returning the active-low one-hot anode pattern for a 2-bit index.
- Sub-module `hex_to_seg7` is a combinational 4-bit to 7-bit decoder, reusable by other display blocks.
- The top level holds the FSM, the slice counter, the scan counters and the output registers.

## Test plan

Every scenario runs with SCAN_DIV=4 and HOLD_CYC=8.

- **Reset:** hold `rst_i` high for 3 cycles with `req_i`=11. Required: `gnt_o`=00, `an_o`=1111, `seg_o`=1111111 throughout; after release, `gnt_o`=01 one cycle later.
- **Single requester scan:** `req_i`=01, `data0_i`=16'h12AF. Required: `an_o` cycles 1110, 1101, 1011, 0111, each for 4 cycles, with `seg_o`=0111000 (F), 0001000 (A), 0010010 (2) and 1001111 (1) respectively.
- **Contention preemption:** hold 01, then raise `req_i[1]`. Required: after 8 contended cycles, `gnt_o` goes 01→10 at a single edge; with both held, grants alternate every 8 cycles.
- **Uncontested hold:** `req_i`=10 held for 100 cycles. Required: `gnt_o` stays 10 and `slice_q` stays 0.
- **Release and tie:** with owner 0 and `req_i[1]` high, drop `req_i[0]` at slice count 7. Required: `gnt_o`=10 next cycle; drop both → 00 and a blank display one cycle after the grant falls.
- **Mid-scan reset:** assert `rst_i` at idx 2 with `gnt_o`=10. Required: the next edge gives `idx_q`=0, `gnt_o`=00, `an_o`=1111.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment display blocks.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } disp_state_t;

    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low one-hot anode select; idx 0 is the rightmost digit.
    function automatic logic [3:0] an_pattern(input logic [1:0] idx);
        an_pattern = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/display_scheduler_hex_to_seg7.sv
// Combinational hex digit to active-low abcdefg segment decoder.
module hex_to_seg7 (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (hex)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin time-sliced arbiter for two requesters sharing the 4-digit
// display, plus the anode scan and registered segment outputs.
module display_scheduler
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 10000,
    parameter int unsigned HOLD_CYC = 5000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_i,
    input  logic [15:0] data0_i,
    input  logic [15:0] data1_i,
    output logic [1:0]  gnt_o,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o
);

    localparam int unsigned DIV_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned SLICE_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(HOLD_CYC - 1);

    disp_state_t        state_q, state_d;
    logic               last_q;
    logic [SLICE_W-1:0] slice_q;
    logic [DIV_W-1:0]   div_q;
    logic [1:0]         idx_q;
    logic [3:0]         an_q;
    logic [6:0]         seg_q;

    logic               other_req;
    logic               slice_done;
    logic [15:0]        src_data;
    logic [3:0]         nibble;
    logic [6:0]         seg_dec;

    assign gnt_o = {state_q == OWN1, state_q == OWN0};
    assign an_o  = an_q;
    assign seg_o = seg_q;

    assign slice_done = (slice_q == SLICE_LAST);

    always_comb begin
        other_req = 1'b0;
        case (state_q)
            OWN0:    other_req = req_i[1];
            OWN1:    other_req = req_i[0];
            default: other_req = 1'b0;
        endcase
    end

    // Release is checked before slice expiry; both give the same handoff.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (&req_i)
                    state_d = last_q ? OWN0 : OWN1;
                else if (req_i[0])
                    state_d = OWN0;
                else if (req_i[1])
                    state_d = OWN1;
            end
            OWN0: begin
                if (!req_i[0])
                    state_d = req_i[1] ? OWN1 : IDLE;
                else if (req_i[1] && slice_done)
                    state_d = OWN1;
            end
            OWN1: begin
                if (!req_i[1])
                    state_d = req_i[0] ? OWN0 : IDLE;
                else if (req_i[0] && slice_done)
                    state_d = OWN0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        src_data = (state_q == OWN1) ? data1_i : data0_i;
        nibble   = src_data[3:0];
        case (idx_q)
            2'd0: nibble = src_data[3:0];
            2'd1: nibble = src_data[7:4];
            2'd2: nibble = src_data[11:8];
            2'd3: nibble = src_data[15:12];
            default: nibble = src_data[3:0];
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .hex (nibble),
        .seg (seg_dec)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            slice_q <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
        end else begin
            state_q <= state_d;

            if ((state_d != state_q) && (state_d != IDLE))
                last_q <= (state_d == OWN1);

            // Only contended ownership ages the slice; an uncontested owner never expires.
            if ((state_d != state_q) || !other_req)
                slice_q <= '0;
            else if (!slice_done)
                slice_q <= slice_q + 1'b1;

            if (div_q == DIV_LAST) begin
                div_q <= '0;
                idx_q <= idx_q + 1'b1;
            end else begin
                div_q <= div_q + 1'b1;
            end

            if (state_q == IDLE) begin
                an_q  <= AN_OFF;
                seg_q <= SEG_BLANK;
            end else begin
                an_q  <= an_pattern(idx_q);
                seg_q <= seg_dec;
            end
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler with SCAN_DIV=4, HOLD_CYC=8.
module tb_display_scheduler;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [1:0]  gnt;
    logic [3:0]  an;
    logic [6:0]  seg;

    typedef struct {
        logic [1:0] gnt;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned tests;
    int unsigned failed;
    int unsigned cyc;
    logic [1:0]  prev_gnt;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    display_scheduler #(
        .SCAN_DIV (4),
        .HOLD_CYC (8)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .data0_i (data0),
        .data1_i (data1),
        .gnt_o   (gnt),
        .an_o    (an),
        .seg_o   (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Display after edge k reflects the grant and digit index held before that edge.
    function automatic logic [10:0] exp_disp(input logic [1:0] g, input int unsigned k);
        int unsigned idx;
        logic [15:0] d;
        logic [3:0]  nib;
        logic [3:0]  a;
        if (g == 2'b00 || k == 0)
            return {4'b1111, 7'b1111111};
        idx = ((k - 1) / 4) % 4;
        d   = g[0] ? data0 : data1;
        nib = d[idx*4 +: 4];
        a   = 4'b1111;
        a[idx] = 1'b0;
        return {a, seg_tab[nib]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc = rst ? 0 : cyc + 1;
    endtask

    task automatic drive_cycle(input logic [1:0] next_gnt);
        exp_t x;
        if (rst) begin
            x.gnt = 2'b00; x.an = 4'b1111; x.seg = 7'b1111111;
        end else begin
            x.gnt = next_gnt;
            {x.an, x.seg} = exp_disp(prev_gnt, cyc + 1);
        end
        sb.push_back(x);
        step();
        prev_gnt = rst ? 2'b00 : next_gnt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        prev_gnt = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(2'b00);
            e = sb.pop_front(); tests++;
            if ({gnt, an, seg} !== {e.gnt, e.an, e.seg}) begin
                failed++;
                $display("FAIL reset_hold: got gnt=%b an=%b seg=%b, expected gnt=%b an=%b seg=%b",
                         gnt, an, seg, e.gnt, e.an, e.seg);
            end
        end
        rst = 1'b0;
        drive_cycle(2'b01);
        e = sb.pop_front(); tests++;
        if ({gnt, an, seg} !== {e.gnt, e.an, e.seg}) begin
            failed++;
            $display("FAIL reset_first_grant: got gnt=%b an=%b seg=%b, expected gnt=%b an=%b seg=%b",
                     gnt, an, seg, e.gnt, e.an, e.seg);
        end
    endtask

    task automatic test_scan();
        do_reset();
        data0 = 16'h12AF;
        data1 = 16'h0000;
        req   = 2'b01;
        for (int i = 0; i < 20; i++) begin
            drive_cycle(2'b01);
            e = sb.pop_front(); tests++;
            if ({gnt, an, seg} !== {e.gnt, e.an, e.seg}) begin
                failed++;
                $display("FAIL scan[%0d]: got gnt=%b an=%b seg=%b, expected gnt=%b an=%b seg=%b",
                         i, gnt, an, seg, e.gnt, e.an, e.seg);
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0] owner;
        do_reset();
        data0 = 16'h3456;
        data1 = 16'h9BCD;
        req   = 2'b01;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(2'b01);
            e = sb.pop_front(); tests++;
            if ({gnt, an, seg} !== {e.gnt, e.an, e.seg}) begin
                failed++;
                $display("FAIL contend_pre[%0d]: got gnt=%b an=%b seg=%b, expected gnt=%b an=%b seg=%b",
                         i, gnt, an, seg, e.gnt, e.an, e.seg);
            end
        end
        req = 2'b11;
        for (int j = 1; j <= 24; j++) begin
            owner = ((j / 8) % 2 == 0) ? 2'b01 : 2'b10;
            drive_cycle(owner);
            e = sb.pop_front(); tests++;
            if ({gnt, an, seg} !== {e.gnt, e.an, e.seg}) begin
                failed++;
                $display("FAIL contend[%0d]: got gnt=%b an=%b seg=%b, expected gnt=%b an=%b seg=%b",
                         j, gnt, an, seg, e.gnt, e.an, e.seg);
            end
        end
    endtask

    task automatic test_uncontested();
        do_reset();
        data0 = 16'h0F0F;
        data1 = 16'hE8D7;
        req   = 2'b10;
        for (int i = 0; i < 100; i++) begin
            drive_cycle(2'b10);
            e = sb.pop_front(); tests++;
            if ({gnt, an, seg} !== {e.gnt, e.an, e.seg} || dut.slice_q !== '0) begin
                failed++;
                $display("FAIL uncontested[%0d]: got gnt=%b an=%b seg=%b slice=%0d, expected gnt=%b an=%b seg=%b slice=0",
                         i, gnt, an, seg, dut.slice_q, e.gnt, e.an, e.seg);
            end
        end
        req = 2'b11;
        for (int j = 1; j <= 8; j++) begin
            drive_cycle((j == 8) ? 2'b01 : 2'b10);
            e = sb.pop_front(); tests++;
            if ({gnt, an, seg} !== {e.gnt, e.an, e.seg}) begin
                failed++;
                $display("FAIL uncontested_preempt[%0d]: got gnt=%b an=%b seg=%b, expected gnt=%b an=%b seg=%b",
                         j, gnt, an, seg, e.gnt, e.an, e.seg);
            end
        end
    endtask

    task automatic test_release();
        do_reset();
        data0 = 16'h4321;
        data1 = 16'hBC65;
        req   = 2'b01;
        drive_cycle(2'b01);
        void'(sb.pop_front());
        req = 2'b11;
        for (int i = 0; i < 7; i++) begin
            drive_cycle(2'b01);
            e = sb.pop_front(); tests++;
            if ({gnt, an, seg} !== {e.gnt, e.an, e.seg}) begin
                failed++;
                $display("FAIL release_contend[%0d]: got gnt=%b an=%b seg=%b, expected gnt=%b an=%b seg=%b",
                         i, gnt, an, seg, e.gnt, e.an, e.seg);
            end
        end
        tests++;
        if (dut.slice_q !== 3'd7) begin
            failed++;
            $display("FAIL release_slice: got slice=%0d, expected 7", dut.slice_q);
        end
        req = 2'b10;
        drive_cycle(2'b10);
        e = sb.pop_front(); tests++;
        if ({gnt, an, seg} !== {e.gnt, e.an, e.seg}) begin
            failed++;
            $display("FAIL release_handoff: got gnt=%b an=%b seg=%b, expected gnt=%b an=%b seg=%b",
                     gnt, an, seg, e.gnt, e.an, e.seg);
        end
        req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(2'b00);
            e = sb.pop_front(); tests++;
            if ({gnt, an, seg} !== {e.gnt, e.an, e.seg}) begin
                failed++;
                $display("FAIL release_idle[%0d]: got gnt=%b an=%b seg=%b, expected gnt=%b an=%b seg=%b",
                         i, gnt, an, seg, e.gnt, e.an, e.seg);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        data1 = 16'hA5C3;
        req   = 2'b10;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(2'b10);
            e = sb.pop_front(); tests++;
            if ({gnt, an, seg} !== {e.gnt, e.an, e.seg}) begin
                failed++;
                $display("FAIL midreset_run[%0d]: got gnt=%b an=%b seg=%b, expected gnt=%b an=%b seg=%b",
                         i, gnt, an, seg, e.gnt, e.an, e.seg);
            end
        end
        tests++;
        if (dut.idx_q !== 2'd2) begin
            failed++;
            $display("FAIL midreset_idx_before: got idx=%0d, expected 2", dut.idx_q);
        end
        rst = 1'b1;
        drive_cycle(2'b00);
        e = sb.pop_front(); tests++;
        if ({gnt, an, seg} !== {e.gnt, e.an, e.seg} || dut.idx_q !== 2'd0) begin
            failed++;
            $display("FAIL midreset: got gnt=%b an=%b seg=%b idx=%0d, expected gnt=%b an=%b seg=%b idx=0",
                     gnt, an, seg, dut.idx_q, e.gnt, e.an, e.seg);
        end
        rst = 1'b0;
    endtask

    initial begin
        tests    = 0;
        failed   = 0;
        cyc      = 0;
        prev_gnt = 2'b00;
        rst      = 1'b1;
        req      = 2'b00;
        data0    = '0;
        data1    = '0;
        test_reset();
        test_scan();
        test_contention();
        test_uncontested();
        test_release();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
